// File: rtl/vending_pkg.sv
// Shared encodings for the change dispenser: FSM states, coin selector codes,
// denomination values and the greedy coin picker.
package vending_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_ISSUE,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    SEL_1 = 2'b00,
    SEL_2 = 2'b01,
    SEL_4 = 2'b10,
    SEL_8 = 2'b11
  } coin_sel_t;

  localparam logic [3:0] COIN_VAL_1 = 4'd1;
  localparam logic [3:0] COIN_VAL_2 = 4'd2;
  localparam logic [3:0] COIN_VAL_4 = 4'd4;
  localparam logic [3:0] COIN_VAL_8 = 4'd8;

  typedef struct packed {
    logic      found;
    coin_sel_t sel;
  } coin_pick_t;

  function automatic logic [3:0] coin_value(input coin_sel_t sel);
    case (sel)
      SEL_1:   return COIN_VAL_1;
      SEL_2:   return COIN_VAL_2;
      SEL_4:   return COIN_VAL_4;
      default: return COIN_VAL_8;
    endcase
  endfunction

  // Largest available denomination not exceeding the remaining amount.
  function automatic coin_pick_t pick_coin(input logic [3:0] remaining,
                                           input logic [3:0] avail);
    coin_pick_t p;
    p.found = 1'b0;
    p.sel   = SEL_1;
    for (int i = 3; i >= 0; i--) begin
      if (!p.found && avail[i] && coin_value(coin_sel_t'(2'(i))) <= remaining) begin
        p.found = 1'b1;
        p.sel   = coin_sel_t'(2'(i));
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/coin_stock.sv
// Per-denomination coin stock counters; only built with CHANGE_DISPENSER_COIN_STOCK_EN.
`ifdef CHANGE_DISPENSER_COIN_STOCK_EN
module coin_stock
  import vending_pkg::*;
#(
  parameter int STOCK_INIT = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       take,
  input  coin_sel_t  take_sel,
  output logic [3:0] avail
);

  logic [3:0] stock [4];

  // NOTE: these are live counters, not storage, so every entry is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) stock[i] <= 4'(STOCK_INIT);
    end else if (take && stock[take_sel] != 4'd0) begin
      stock[take_sel] <= stock[take_sel] - 4'd1;
    end
  end

  always_comb begin
    avail = 4'b0000;
    for (int i = 0; i < 4; i++) avail[i] = (stock[i] != 4'd0);
  end

endmodule
`endif

// File: rtl/change_dispenser.sv
// Greedy change dispenser FSM driving a one-coin-at-a-time ejection handshake.
// Optional stock tracking is enabled by defining CHANGE_DISPENSER_COIN_STOCK_EN.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int ACK_TIMEOUT     = 15,
  parameter int COIN_STOCK_INIT = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       change_valid,
  input  logic [3:0] change_amount,
  output logic       change_ready,
  output logic       coin_req,
  output logic [1:0] coin_sel,
  input  logic       coin_ack,
  output logic [3:0] dispensed,
  output logic       done,
  output logic       redlight
);

  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);

  state_t            state;
  logic [3:0]        remaining;
  coin_sel_t         sel_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        avail;
  logic              coin_taken;
  coin_pick_t        pick;

  assign change_ready = (state == ST_IDLE);
  assign coin_sel     = sel_q;
  assign coin_taken   = (state == ST_ISSUE) && coin_ack;
  assign pick         = pick_coin(remaining, avail);

`ifdef CHANGE_DISPENSER_COIN_STOCK_EN
  coin_stock #(
    .STOCK_INIT (COIN_STOCK_INIT)
  ) u_coin_stock (
    .clk      (clk),
    .rst      (rst),
    .take     (coin_taken),
    .take_sel (sel_q),
    .avail    (avail)
  );
`else
  // Unlimited supply; the stock parameter has no effect in this build.
  assign avail = {4{COIN_STOCK_INIT >= 0}};
`endif

  // NOTE: all state below is registered with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      remaining <= 4'd0;
      dispensed <= 4'd0;
      sel_q     <= SEL_1;
      coin_req  <= 1'b0;
      done      <= 1'b0;
      redlight  <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (change_valid) begin
            remaining <= change_amount;
            dispensed <= 4'd0;
            redlight  <= 1'b0;
            state     <= ST_SELECT;
          end
        end
        ST_SELECT: begin
          if (remaining == 4'd0) begin
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (pick.found) begin
            sel_q    <= pick.sel;
            coin_req <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_ISSUE;
          end else begin
            redlight <= 1'b1;
            state    <= ST_ERROR;
          end
        end
        ST_ISSUE: begin
          // An ack on the final wait cycle is checked first so it wins.
          if (coin_ack) begin
            remaining <= remaining - coin_value(sel_q);
            dispensed <= dispensed + coin_value(sel_q);
            wait_cnt  <= '0;
            coin_req  <= 1'b0;
            state     <= ST_SELECT;
          end else if (wait_cnt == WAIT_W'(ACK_TIMEOUT - 1)) begin
            wait_cnt <= '0;
            coin_req <= 1'b0;
            redlight <= 1'b1;
            state    <= ST_ERROR;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_DONE:  state <= ST_IDLE;
        ST_ERROR: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser; inputs change and outputs
// are sampled on the falling clock edge.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       rst;
  logic       change_valid;
  logic [3:0] change_amount;
  logic       change_ready;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic       coin_ack;
  logic [3:0] dispensed;
  logic       done;
  logic       redlight;

  int n_vec = 0;
  int n_bad = 0;

  change_dispenser #(
    .ACK_TIMEOUT     (15),
    .COIN_STOCK_INIT (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .change_valid  (change_valid),
    .change_amount (change_amount),
    .change_ready  (change_ready),
    .coin_req      (coin_req),
    .coin_sel      (coin_sel),
    .coin_ack      (coin_ack),
    .dispensed     (dispensed),
    .done          (done),
    .redlight      (redlight)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; change_valid = 1'b0; change_amount = 4'd0; coin_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one request for exactly one edge; returns in cycle N+1.
  task automatic request(input logic [3:0] amt);
    check("ready_before_req", change_ready, 1);
    change_amount = amt; change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0; change_amount = 4'd0;
  endtask

  task automatic wait_req(input string tag);
    int k = 0;
    while (!coin_req && k < 40) begin @(negedge clk); k++; end
    check(tag, coin_req, 1);
  endtask

  // Services coins until IDLE, acking on the ack_at-th cycle of each coin_req.
  task automatic serve(input int ack_at, output logic [7:0] hist, output int req_cyc,
                       output int first_req, output int done_cyc, output int ready_cyc);
    int hi = 0;
    hist = 8'h00; req_cyc = 0; first_req = -1; done_cyc = -1; ready_cyc = -1;
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (change_ready) begin ready_cyc = cyc; break; end
      if (done) done_cyc = cyc;
      if (coin_req) begin
        hi++; req_cyc++;
        if (first_req < 0) first_req = cyc;
        if (hi == 1) hist = {hist[5:0], coin_sel};
        coin_ack = (hi == ack_at);
      end else begin
        hi = 0; coin_ack = 1'b0;
      end
      @(negedge clk);
    end
    coin_ack = 1'b0;
    check("serve_bounded", ready_cyc > 0, 1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [7:0] hist;
    int req_cyc, first_req, done_cyc, ready_cyc;

    apply_reset();
    check("rst_ready", change_ready, 1);
    check("rst_coin_req", coin_req, 0);
    check("rst_coin_sel", coin_sel, 0);
    check("rst_dispensed", dispensed, 0);
    check("rst_done", done, 0);
    check("rst_redlight", redlight, 0);

    // Amount 13: coins 8,4,1 with ack in the second coin_req cycle.
    request(4'd13);
    serve(2, hist, req_cyc, first_req, done_cyc, ready_cyc);
    check("a13_sels", hist, 8'h38);
    check("a13_first_req", first_req, 2);
    check("a13_req_cycles", req_cyc, 6);
    check("a13_done_cyc", done_cyc, 11);
    check("a13_ready_cyc", ready_cyc, 12);
    check("a13_dispensed", dispensed, 13);
    check("a13_redlight", redlight, 0);

    // Amount 2 with no ack: 15 request cycles, then error.
    request(4'd2);
    serve(99, hist, req_cyc, first_req, done_cyc, ready_cyc);
    check("to_req_cycles", req_cyc, 15);
    check("to_ready_cyc", ready_cyc, 18);
    check("to_redlight", redlight, 1);
    check("to_dispensed", dispensed, 0);
    check("to_no_done", done_cyc, -1);

    // Amount 0: no coin, done at N+2, ready at N+3; redlight cleared on accept.
    request(4'd0);
    check("a0_redlight_clr", redlight, 0);
    serve(2, hist, req_cyc, first_req, done_cyc, ready_cyc);
    check("a0_req_cycles", req_cyc, 0);
    check("a0_done_cyc", done_cyc, 2);
    check("a0_ready_cyc", ready_cyc, 3);

    // Ack on the timeout cycle itself is counted.
    apply_reset();
    request(4'd1);
    serve(15, hist, req_cyc, first_req, done_cyc, ready_cyc);
    check("tw_req_cycles", req_cyc, 15);
    check("tw_done_cyc", done_cyc, 18);
    check("tw_redlight", redlight, 0);
    check("tw_dispensed", dispensed, 1);

    // Amount 12, reset during the second coin_req with an ack in flight.
    apply_reset();
    request(4'd12);
    wait_req("r12_coin1");
    check("r12_sel1", coin_sel, 2'b11);
    @(negedge clk); coin_ack = 1'b1;
    @(negedge clk); coin_ack = 1'b0;
    wait_req("r12_coin2");
    check("r12_sel2", coin_sel, 2'b10);
    check("r12_mid_dispensed", dispensed, 8);
    rst = 1'b1; coin_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0; coin_ack = 1'b0;
    check("r12_rst_coin_req", coin_req, 0);
    check("r12_rst_dispensed", dispensed, 0);
    check("r12_rst_ready", change_ready, 1);
    request(4'd3);
    serve(2, hist, req_cyc, first_req, done_cyc, ready_cyc);
    check("a3_sels", hist, 8'h04);
    check("a3_dispensed", dispensed, 3);
    check("a3_done_seen", done_cyc > 0, 1);

    // change_valid while in ISSUE must be ignored.
    request(4'd6);
    wait_req("iv_coin1");
    change_valid = 1'b1; change_amount = 4'd9;
    repeat (2) @(negedge clk);
    change_valid = 1'b0; change_amount = 4'd0;
    serve(2, hist, req_cyc, first_req, done_cyc, ready_cyc);
    check("iv_sels", hist, 8'h09);
    check("iv_dispensed", dispensed, 6);
    check("iv_done_seen", done_cyc > 0, 1);
    @(negedge clk);
    check("iv_no_queue_ready", change_ready, 1);
    check("iv_no_queue_req", coin_req, 0);

    // coin_ack outside ISSUE has no effect.
    coin_ack = 1'b1;
    request(4'd0);
    repeat (2) @(negedge clk);
    coin_ack = 1'b0;
    check("ack_idle_dispensed", dispensed, 0);
    check("ack_idle_ready", change_ready, 1);

    // Amount 15 uses one coin of each denomination.
    apply_reset();
    request(4'd15);
    serve(2, hist, req_cyc, first_req, done_cyc, ready_cyc);
    check("a15_sels", hist, 8'hE4);
    check("a15_dispensed", dispensed, 15);
    check("a15_redlight", redlight, 0);
`ifdef CHANGE_DISPENSER_COIN_STOCK_EN
    // Stock of one per denomination is now exhausted.
    request(4'd15);
    serve(2, hist, req_cyc, first_req, done_cyc, ready_cyc);
    check("empty_req_cycles", req_cyc, 0);
    check("empty_redlight", redlight, 1);
    check("empty_dispensed", dispensed, 0);
    check("empty_ready_cyc", ready_cyc, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 SHALL provide parameter ACK_TIMEOUT, default 15: max cycles coin_req may wait for coin_ack.
REQ-002 SHALL provide parameter COIN_STOCK_INIT, default 5: initial coins per denomination (used only with COIN_STOCK_EN).
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 change_valid  in  1  request: remaining customer money to return.
REQ-006 change_amount  in  4  amount to return, unsigned units.
REQ-007 change_ready  out  1  high only in IDLE; request accepted when change_valid and change_ready are both high at a posedge.
REQ-008 coin_req  out  1  asks the coin mechanism to eject one coin.
REQ-009 coin_sel  out  2  denomination for coin_req: 00=1, 01=2, 10=4, 11=8.
REQ-010 coin_ack  in  1  mechanism ejected the coin; counted only when coin_req is high.
REQ-011 dispensed  out  4  running total ejected in current request.
REQ-012 done  out  1  one-cycle pulse: request fully paid.
REQ-013 redlight  out  1  error flag, sticky until next accepted request.

Function
REQ-014 SHALL implement FSM states IDLE, SELECT, ISSUE, DONE, ERROR.
REQ-015 IDLE + accept at edge N: latch change_amount into remaining, clear dispensed and redlight, enter SELECT (cycle N+1).
REQ-016 SELECT: remaining==0 -> DONE; else latch largest d in {8,4,2,1} with d<=remaining (and stock[d]>0 under COIN_STOCK_EN) into coin_sel -> ISSUE; no eligible d -> ERROR.
REQ-017 ISSUE: coin_req=1, coin_sel stable; first coin_req at cycle N+2 after acceptance.
REQ-018 coin_ack sampled high in ISSUE: remaining -= d, dispensed += d, wait counter cleared, -> SELECT (coin_req low for exactly one cycle between coins).
REQ-019 ISSUE held ACK_TIMEOUT cycles without coin_ack: -> ERROR; coin_ack arriving on the timeout cycle itself SHALL win (coin counted, no error).
REQ-020 DONE: done=1 for one cycle, -> IDLE.
REQ-021 ERROR: redlight set, one cycle, -> IDLE; dispensed holds value reached.
REQ-022 Arithmetic 4-bit; greedy choice guarantees dispensed never exceeds change_amount, no wrap.
REQ-023 change_valid outside IDLE SHALL be ignored (no queuing).
REQ-024 coin_ack outside ISSUE SHALL be ignored.

Reset
REQ-025 rst SHALL force IDLE, remaining=0, dispensed=0, coin_sel=00, coin_req=0, done=0, redlight=0, wait counter=0, and (with COIN_STOCK_EN) every stock=COIN_STOCK_INIT on the next posedge, including mid-ISSUE; an in-flight coin is not counted.
REQ-026 change_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-027 Macro CHANGE_DISPENSER_COIN_STOCK_EN: defined -> four 4-bit stock counters, decremented on each acked coin of that denomination; empty denominations skipped; insufficient coins -> ERROR.
REQ-028 Undefined -> no stock counters; supply treated as unlimited; ERROR reachable only via timeout.

Structure
REQ-029 Shared package vending_pkg SHALL hold FSM state encoding, coin_sel encoding and denomination-value constants (1,2,4,8).
REQ-030 Stock counters SHALL live in one sub-module coin_stock (present only under the macro); the rest is a single FSM module.

Verification
REQ-031 amount 13, ack one cycle after each coin_req -> coin_sel 11,10,00; dispensed 13; done pulse; redlight 0.
REQ-032 amount 0 -> no coin_req; done at cycle N+2; change_ready back at N+3.
REQ-033 amount 2, coin_ack tied low -> coin_req high 15 cycles, then redlight=1, dispensed=0, change_ready=1.
REQ-034 macro on, COIN_STOCK_INIT=1: amount 15 -> coins 8,4,2,1, done; second amount 15 -> no coin_req, redlight=1, dispensed=0.
REQ-035 amount 12; rst during second coin_req -> next cycle coin_req=0, dispensed=0, IDLE; new request 3 -> coins 2,1.
REQ-036 change_valid pulsed while in ISSUE -> ignored; first request completes with unchanged dispensed total.
